// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer for a shared signed ALU with a local register file
//
// Accepts register-to-register commands over valid/ready, fetches operands from
// the register file, drives the external ALU and writes the result back.
// Shift ops (100/101) are iterated through the ALU's 1-bit shift, cnt+1 passes.
// Branch ops (110/111) never write back; they report the ALU's take_branch.
//
// Optional build macro: ALU_SEQ_OVF_TRAP_EN
//   defined   : an overflowing add suppresses write-back, still pulses o_done,
//               then parks the sequencer in TRAP (o_cmd_ready=0) until reset.
//   undefined : overflowed sums are written back; only o_ovf_sticky records them.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake (ready only in IDLE)
//   i_cmd_op/rd/ra/rb/cnt       op code, dest/src registers, extra shift passes
//   i_ld_en/addr/data           host preload write (honoured only in IDLE)
//   i_dbg_addr / o_dbg_data     combinational register read
//   o_alu_a/b/s                 registered ALU operands and op select
//   i_alu_f/ovf/br              ALU result, overflow, take_branch
//   o_done                      one-cycle completion pulse
//   o_result                    last result, held until the next o_done
//   o_ovf_sticky                set by any add overflow, cleared by reset
//   o_branch_taken              pulses with o_done for a taken 110/111
module alu_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int CNT_W  = 3,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [RA_W-1:0]   i_cmd_rd,
    input  logic [RA_W-1:0]   i_cmd_ra,
    input  logic [RA_W-1:0]   i_cmd_rb,
    input  logic [CNT_W-1:0]  i_cmd_cnt,
    input  logic              i_ld_en,
    input  logic [RA_W-1:0]   i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic [RA_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [2:0]        o_alu_s,
    input  logic [DATA_W-1:0] i_alu_f,
    input  logic              i_alu_ovf,
    input  logic              i_alu_br,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf_sticky,
    output logic              o_branch_taken
);
`ifdef ALU_SEQ_OVF_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
`endif
    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic [2:0]          r_op;
    logic [RA_W-1:0]     r_rd;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [2:0]          r_alu_s;
    logic [DATA_W-1:0]   r_result;
    logic                r_br;
    logic                r_sticky;
    logic                w_accept;
    logic                w_more;
    logic                w_branch_op;
    logic                w_add_ovf;
    logic                w_wr_en;
`ifdef ALU_SEQ_OVF_TRAP_EN
    logic                r_trap;
`endif

    assign o_cmd_ready    = r_state == S_IDLE;
    assign w_accept       = i_cmd_valid && o_cmd_ready;
    assign w_branch_op    = r_op[2:1] == 2'b11;
    // Shift ops loop in EXEC while extra passes remain
    assign w_more         = r_op[2:1] == 2'b10 && r_cnt != '0;
    assign w_add_ovf      = r_op == 3'b000 && i_alu_ovf;
`ifdef ALU_SEQ_OVF_TRAP_EN
    assign w_wr_en        = r_state == S_WB && !w_branch_op && !r_trap;
`else
    assign w_wr_en        = r_state == S_WB && !w_branch_op;
`endif
    assign o_done         = r_state == S_WB;
    assign o_branch_taken = o_done && r_br;
    assign o_dbg_data     = r_regs[i_dbg_addr];
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_s        = r_alu_s;
    assign o_result       = r_result;
    assign o_ovf_sticky   = r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = w_more ? S_EXEC : S_WB;
`ifdef ALU_SEQ_OVF_TRAP_EN
            S_WB:    w_next = r_trap ? S_TRAP : S_IDLE;
            S_TRAP:  w_next = S_TRAP;
`else
            S_WB:    w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_s  <= '0;
            r_result <= '0;
            r_br     <= 1'b0;
            r_sticky <= 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
            r_trap   <= 1'b0;
`endif
        end else begin
            // Preload and write-back live in different states, so never collide
            if (o_cmd_ready && i_ld_en)
                r_regs[i_ld_addr] <= i_ld_data;
            if (w_wr_en)
                r_regs[r_rd] <= r_result;
            // Operands are latched here, so a same-cycle preload is not seen
            if (w_accept) begin
                r_op    <= i_cmd_op;
                r_rd    <= i_cmd_rd;
                r_cnt   <= i_cmd_cnt;
                r_alu_a <= r_regs[i_cmd_ra];
                r_alu_b <= r_regs[i_cmd_rb];
                r_alu_s <= i_cmd_op;
            end
            if (r_state == S_EXEC) begin
                if (w_add_ovf)
                    r_sticky <= 1'b1;
                if (w_more) begin
                    r_alu_a <= i_alu_f;
                    r_cnt   <= r_cnt - 1'b1;
                end else begin
                    r_result <= w_branch_op ? '0 : i_alu_f;
                    r_br     <= w_branch_op && i_alu_br;
`ifdef ALU_SEQ_OVF_TRAP_EN
                    r_trap   <= w_add_ovf;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and randomized checks of alu_seq_ctrl against a behavioural model
module tb_alu_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_cmd_valid, o_cmd_ready;
    logic [2:0] i_cmd_op;
    logic [1:0] i_cmd_rd, i_cmd_ra, i_cmd_rb;
    logic [2:0] i_cmd_cnt;
    logic       i_ld_en;
    logic [1:0] i_ld_addr;
    logic [7:0] i_ld_data;
    logic [1:0] i_dbg_addr;
    logic [7:0] o_dbg_data, o_alu_a, o_alu_b, i_alu_f, o_result;
    logic [2:0] o_alu_s;
    logic       i_alu_ovf, i_alu_br, o_done, o_ovf_sticky, o_branch_taken;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] m_r [4];
    bit         m_sticky;
    bit         m_trap;

    always #5 clk = ~clk;

    // ALU environment: 000 add, 001 sub, 010 and, 011 or, 100 sra1, 101 shl1, 110 beq, 111 bne
    function automatic logic [7:0] f_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return 8'($signed(a) >>> 1);
            3'd5:    return a << 1;
            default: return a - b;
        endcase
    endfunction

    function automatic logic f_ovf(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] f;
        f = f_alu(s, a, b);
        if (s == 3'd0) return a[7] == b[7] && f[7] != a[7];
        if (s == 3'd1) return a[7] != b[7] && f[7] != a[7];
        return 1'b0;
    endfunction

    function automatic logic f_br(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        return (s == 3'd6 && a == b) || (s == 3'd7 && a != b);
    endfunction

    assign i_alu_f   = f_alu(o_alu_s, o_alu_a, o_alu_b);
    assign i_alu_ovf = f_ovf(o_alu_s, o_alu_a, o_alu_b);
    assign i_alu_br  = f_br(o_alu_s, o_alu_a, o_alu_b);

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_rd(i_cmd_rd), .i_cmd_ra(i_cmd_ra), .i_cmd_rb(i_cmd_rb),
        .i_cmd_cnt(i_cmd_cnt),
        .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_s(o_alu_s),
        .i_alu_f(i_alu_f), .i_alu_ovf(i_alu_ovf), .i_alu_br(i_alu_br),
        .o_done(o_done), .o_result(o_result), .o_ovf_sticky(o_ovf_sticky),
        .o_branch_taken(o_branch_taken)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_sticky = 1'b0;
        m_trap = 1'b0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            i_dbg_addr = 2'(i);
            #1;
            check("regfile", o_dbg_data, m_r[i]);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!o_cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic ld(input logic [1:0] a, input logic [7:0] d);
        wait_ready();
        i_ld_en = 1'b1;
        i_ld_addr = a;
        i_ld_data = d;
        @(posedge clk);
        @(negedge clk);
        i_ld_en = 1'b0;
        m_r[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        i_ld_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    // Issues one command and returns at the negedge where o_done is seen
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [2:0] cnt, input bit ld_now,
                          input logic [1:0] la, input logic [7:0] ldd, input bit ld_busy);
        logic [7:0] a, b, res;
        int         k, passes;
        bit         ovf;
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_rd = rd;
        i_cmd_ra = ra;
        i_cmd_rb = rb;
        i_cmd_cnt = cnt;
        wait_ready();
        check("accept_ready", o_cmd_ready, 1);
        check("done_idle", o_done, 0);
        a = m_r[ra];
        b = m_r[rb];
        i_ld_en = ld_now;
        i_ld_addr = la;
        i_ld_data = ldd;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_ld_en = ld_busy;
        i_ld_addr = 2'($urandom);
        i_ld_data = 8'($urandom);
        if (ld_now) m_r[la] = ldd;
        passes = (op == 3'd4 || op == 3'd5) ? int'(cnt) + 1 : 1;
        res = a;
        for (int p = 0; p < passes; p++) res = f_alu(op, res, b);
        ovf = op == 3'd0 && f_ovf(op, a, b);
        k = 1;
        while (!o_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        i_ld_en = 1'b0;
        check("latency", 16'(k), 16'(passes + 1));
        check("result", o_result, op[2:1] == 2'b11 ? 8'h00 : res);
        check("branch_taken", o_branch_taken, op[2:1] == 2'b11 && f_br(op, a, b));
        if (ovf) m_sticky = 1'b1;
        check("ovf_sticky", o_ovf_sticky, m_sticky);
`ifdef ALU_SEQ_OVF_TRAP_EN
        if (ovf) m_trap = 1'b1;
`endif
        if (op[2:1] != 2'b11 && !m_trap) m_r[rd] = res;
    endtask

    task automatic after_trap();
        repeat (3) begin
            @(negedge clk);
            check("trap_ready", o_cmd_ready, 0);
        end
        check_regs();
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op = '0;
        i_cmd_rd = '0;
        i_cmd_ra = '0;
        i_cmd_rb = '0;
        i_cmd_cnt = '0;
        i_ld_en = 1'b0;
        i_ld_addr = '0;
        i_ld_data = '0;
        i_dbg_addr = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", o_cmd_ready, 1);
        check("rst_done", o_done, 0);
        check("rst_sticky", o_ovf_sticky, 0);
        check("rst_result", o_result, 0);
        check("rst_alu_a", o_alu_a, 0);
        check("rst_alu_s", o_alu_s, 0);
        check_regs();
        rst_n = 1'b1;
        @(negedge clk);

        // basic add
        ld(0, 8'd5);
        ld(1, 8'd3);
        do_cmd(3'd0, 2, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("done_pulse", o_done, 0);
        check_regs();

        // overflowing add
        ld(0, 8'h70);
        ld(1, 8'h20);
        do_cmd(3'd0, 3, 0, 1, 0, 0, 0, 0, 0);
        if (m_trap) after_trap();
        else begin
            @(negedge clk);
            check_regs();
        end

        // multi-pass arithmetic shift right
        ld(0, 8'h80);
        do_cmd(3'd4, 1, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk);
        check_regs();

        // branches
        ld(0, 8'd7);
        ld(1, 8'd7);
        do_cmd(3'd6, 2, 0, 1, 0, 0, 0, 0, 0);
        do_cmd(3'd7, 2, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_regs();

        // preload in the accept cycle, ignored preload while busy, ra==rb==rd, sub overflow
        do_cmd(3'd0, 3, 0, 1, 0, 1, 0, 8'h11, 0);
        do_cmd(3'd1, 2, 0, 3, 0, 0, 0, 0, 1);
        do_cmd(3'd0, 1, 1, 1, 0, 0, 0, 0, 0);
        ld(0, 8'h80);
        ld(1, 8'h01);
        do_cmd(3'd1, 2, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_regs();

        // full shift count
        ld(2, 8'h01);
        do_cmd(3'd5, 3, 2, 2, 3'd6, 0, 0, 0, 0);
        do_cmd(3'd5, 3, 2, 2, 3'd7, 0, 0, 0, 0);
        @(negedge clk);
        check_regs();

        // reset in the middle of a command
        ld(0, 8'h12);
        ld(1, 8'h34);
        wait_ready();
        i_cmd_valid = 1'b1;
        i_cmd_op = 3'd0;
        i_cmd_rd = 2;
        i_cmd_ra = 0;
        i_cmd_rb = 1;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        check("busy_ready", o_cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_done", o_done, 0);
        check("abort_ready", o_cmd_ready, 1);
        @(negedge clk);
        check("abort_done2", o_done, 0);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("abort_sticky", o_ovf_sticky, 0);
        check_regs();

        // randomized command stream
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) ld(2'($urandom), 8'($urandom));
            do_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                   bit'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
            if (m_trap) after_trap();
            else if (t % 4 == 3) begin
                @(negedge clk);
                check_regs();
            end
        end
        @(negedge clk);
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
